// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Also holds the load-use detection rule so every user applies the same check.
package pipeline_ctrl_pkg;

    localparam logic       ST_RUN      = 1'b0;
    localparam logic       ST_MDU_WAIT = 1'b1;
    localparam logic [4:0] REG_ZERO    = 5'd0;

    typedef enum logic {
        StRun     = ST_RUN,
        StMduWait = ST_MDU_WAIT
    } hz_state_e;

    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and flush performance counters for the hazard controller.
// stall_cycles wraps at 2^32; flush_count saturates at its maximum.
module hazard_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: load-use stalls, taken-branch flushes
// and front-end hold while a multi-cycle mult/div occupies EX.
module hazard_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        ex_mdu_start,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             hazard;
    logic             flush_evt;

    assign hazard = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    // Mealy outputs; reset forces the free-running defaults regardless of inputs.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mdu_busy    = 1'b0;
        flush_evt   = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        if (rst_n) begin
            unique case (state_q)
                StRun: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_evt   = 1'b1;
                    end else begin
                        if (hazard) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        if (ex_mdu_start) begin
                            state_d    = StMduWait;
                            wait_cnt_d = WaitLoad;
                        end
                    end
                end
                StMduWait: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    mdu_busy    = 1'b1;
                    if (wait_cnt_q == WaitLast) begin
                        state_d    = StRun;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WaitLast;
                    end
                end
                default: begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    hazard_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (~pc_write),
        .flush        (flush_evt),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the write (stall) and flush controls consumed by the IF/ID register, plus PC-write and ID/EX bubble controls.
- Detects load-use hazards and taken branches, and holds the front end for multi-cycle multiply/divide ops.
- Keeps stall and flush performance counters.

Parameters:
- MDU_LATENCY, 4: total EX cycles of a mult/div; front end stalls MDU_LATENCY-1 cycles; legal range 2..16.
- CNT_W, 4: width of the MDU wait counter; must hold MDU_LATENCY-1.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination rt of the instruction in EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- ex_mdu_start  in  1  mult/div entered EX this cycle
- pc_write  out  1  PC register write enable
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID clear; only meaningful with if_id_write=1
- id_ex_flush  out  1  insert bubble into ID/EX
- mdu_busy  out  1  high while in MDU_WAIT
- stall_cycles  out  32  count of cycles with pc_write=0
- flush_count  out  16  count of taken-branch flushes

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
- Reset (rst_n=0): state=RUN, wait counter=0, stall_cycles=0, flush_count=0.
- While in reset, outputs are forced to pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, mdu_busy=0.
- Control outputs are combinational from state and current inputs (Mealy), so they act in the same cycle. The counters are registered.
- FSM states: RUN and MDU_WAIT.
- RUN priority, highest first:
  - 1) ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; flush_count increments on the edge.
  - 2) Load-use hazard, defined as ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1. This is a one-cycle stall that clears naturally when the load advances.
  - 3) Otherwise: pc_write=1, if_id_write=1, both flushes 0.
- RUN transitions:
  - RUN -> MDU_WAIT when ex_mdu_start=1 and ex_branch_taken=0; wait counter loads MDU_LATENCY-1.
  - The issuing cycle itself is not stalled; the load-use rule still applies in that cycle.
- ex_branch_taken and ex_mdu_start high together is illegal (same stage). The branch wins and MDU_WAIT is not entered; the bench flags it as an error.
- MDU_WAIT outputs: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1, mdu_busy=1.
- In MDU_WAIT, ex_branch_taken, ex_mdu_start and load-use are ignored, since EX holds only bubbles.
- MDU_WAIT counter: decrements each cycle. On the edge where counter==1, go to RUN with counter=0. Exactly MDU_LATENCY-1 stall cycles result.
- stall_cycles: increments on every edge where pc_write=0; wraps 0xFFFFFFFF->0.
- flush_count: increments per taken-branch flush; saturates at 0xFFFF.
- Reset asserted mid-MDU_WAIT: immediate return to RUN, counter cleared, outputs forced as above, no residual stall after release.
- Register 0: ex_rt==0 never causes a stall.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encoding constants ST_RUN=1'b0, ST_MDU_WAIT=1'b1;
  - register-zero constant REG_ZERO=5'd0.
- One natural sub-module, hazard_perf_counters, owns stall_cycles (wrapping) and flush_count (saturating), with inputs clk, rst_n, stall, flush.
- The FSM and detection logic stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles=1 after the edge. Same stimulus with ex_rt=0 -> no stall.
- rt dependency: ex_rt=9, id_rt=9 -> stall only when id_uses_rt=1; with id_uses_rt=0 -> pc_write=1.
- Branch vs load-use: ex_branch_taken=1 together with a load-use match -> if_id_write=1, if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1.
- MDU (MDU_LATENCY=4): ex_mdu_start pulse in cycle 0 -> cycle 0 unstalled; cycles 1-3 mdu_busy=1, pc_write=0; cycle 4 RUN; stall_cycles=3.
- Reset in cycle 2 of MDU_WAIT: rst_n low mid-cycle -> outputs are immediately pc_write=1, mdu_busy=0; after release the state is RUN and both counters are 0.
- Saturation/wrap: preload or drive 65540 branch flushes -> flush_count holds 0xFFFF. Force stall_cycles to 0xFFFFFFFF then one stall -> 0.
